// File: rtl/mux_arb_rr.sv
// N-channel WIDE-bit multiplexer with a round-robin arbiter feeding a
// registered valid/ready output stage; selection is internal and fair.
module mux_arb_rr #(
  parameter int WIDE = 32,
  parameter int N    = 4,
  parameter int SW   = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*WIDE-1:0] in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  output logic [WIDE-1:0] out_data,
  output logic [SW-1:0]   out_slct,
  output logic            out_valid,
  input  logic            out_ready
);

  logic [WIDE-1:0] out_data_q,  out_data_d;
  logic [SW-1:0]   out_slct_q,  out_slct_d;
  logic            out_valid_q, out_valid_d;
  logic [SW-1:0]   last_q,      last_d;

  logic            load;
  logic            xfer;
  logic            found;
  logic [N-1:0]    masked;
  logic [N-1:0]    grant;
  logic [SW-1:0]   grant_idx;
  logic [WIDE-1:0] grant_data;

  // Channels above last win first; if none is valid, wrap to the lowest valid index.
  always_comb begin
    masked = '0;
    grant  = '0;
    found  = 1'b0;
    for (int i = 0; i < N; i++) begin
      masked[i] = in_valid[i] && (i > int'(last_q));
    end
    for (int i = 0; i < N; i++) begin
      if (!found && masked[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && in_valid[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    grant_idx  = '0;
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        grant_idx  = SW'(i);
        grant_data = in_data[i*WIDE +: WIDE];
      end
    end
  end

  assign load     = (!out_valid_q || out_ready) && rst_n;
  assign in_ready = grant & {N{load}};
  assign xfer     = found && load;

  always_comb begin
    out_data_d  = out_data_q;
    out_slct_d  = out_slct_q;
    out_valid_d = out_valid_q;
    last_d      = last_q;
    if (xfer) begin
      out_data_d  = grant_data;
      out_slct_d  = grant_idx;
      out_valid_d = 1'b1;
      last_d      = grant_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Reset leaves last at N-1 so channel 0 is first in line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_slct_q  <= '0;
      out_valid_q <= 1'b0;
      last_q      <= SW'(N - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_slct_q  <= out_slct_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_slct  = out_slct_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_arb_rr.sv
// Directed bench for mux_arb_rr with WIDE=4, N=4; channel i carries 10+i.
module tb_mux_arb_rr;

  localparam int WIDE = 4;
  localparam int N    = 4;
  localparam int SW   = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*WIDE-1:0] in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [WIDE-1:0] out_data;
  logic [SW-1:0]   out_slct;
  logic            out_valid;
  logic            out_ready;

  int checks = 0;
  int errors = 0;

  mux_arb_rr #(.WIDE(WIDE), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_slct  (out_slct),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change at the falling edge and settle 1 time unit before checks.
  task automatic applyStimulus(input logic rst, input logic [N-1:0] valid, input logic ordy);
    @(negedge clk);
    rst_n     = rst;
    in_valid  = valid;
    out_ready = ordy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [N-1:0] exp_ready,
                             input logic exp_valid, input logic [WIDE-1:0] exp_data,
                             input logic [SW-1:0] exp_slct);
    chk({tag, ".in_ready"},  32'(in_ready),  32'(exp_ready));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(exp_valid));
    chk({tag, ".out_data"},  32'(out_data),  32'(exp_data));
    chk({tag, ".out_slct"},  32'(out_slct),  32'(exp_slct));
  endtask

  initial begin
    in_data   = {4'd13, 4'd12, 4'd11, 4'd10};
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = 1'b0;

    applyStimulus(1'b0, 4'b1111, 1'b1);
    chk("rst0.in_ready", 32'(in_ready), 32'd0);
    applyStimulus(1'b0, 4'b1111, 1'b1);
    checkOutput("rst1", 4'b0000, 1'b0, 4'd0, 2'd0);

    applyStimulus(1'b1, 4'b1111, 1'b1);
    checkOutput("rr0", 4'b0001, 1'b0, 4'd0, 2'd0);
    applyStimulus(1'b1, 4'b1111, 1'b1);
    checkOutput("rr1", 4'b0010, 1'b1, 4'd10, 2'd0);
    applyStimulus(1'b1, 4'b1111, 1'b1);
    checkOutput("rr2", 4'b0100, 1'b1, 4'd11, 2'd1);
    applyStimulus(1'b1, 4'b1111, 1'b1);
    checkOutput("rr3", 4'b1000, 1'b1, 4'd12, 2'd2);
    applyStimulus(1'b1, 4'b1111, 1'b1);
    checkOutput("rr4", 4'b0001, 1'b1, 4'd13, 2'd3);
    applyStimulus(1'b1, 4'b1111, 1'b1);
    checkOutput("rr5", 4'b0010, 1'b1, 4'd10, 2'd0);
    applyStimulus(1'b1, 4'b1111, 1'b1);
    checkOutput("rr6", 4'b0100, 1'b1, 4'd11, 2'd1);
    applyStimulus(1'b1, 4'b1111, 1'b1);
    checkOutput("rr7", 4'b1000, 1'b1, 4'd12, 2'd2);

    applyStimulus(1'b1, 4'b1111, 1'b1);
    checkOutput("bp0", 4'b0001, 1'b1, 4'd13, 2'd3);
    applyStimulus(1'b1, 4'b1111, 1'b0);
    checkOutput("bp1", 4'b0000, 1'b1, 4'd10, 2'd0);
    applyStimulus(1'b1, 4'b1111, 1'b0);
    checkOutput("bp2", 4'b0000, 1'b1, 4'd10, 2'd0);
    applyStimulus(1'b1, 4'b1111, 1'b0);
    checkOutput("bp3", 4'b0000, 1'b1, 4'd10, 2'd0);
    applyStimulus(1'b1, 4'b1111, 1'b1);
    checkOutput("bp4", 4'b0010, 1'b1, 4'd10, 2'd0);
    applyStimulus(1'b1, 4'b0000, 1'b1);
    checkOutput("bp5", 4'b0000, 1'b1, 4'd11, 2'd1);

    applyStimulus(1'b1, 4'b0100, 1'b1);
    checkOutput("one0", 4'b0100, 1'b0, 4'd11, 2'd1);
    applyStimulus(1'b1, 4'b0100, 1'b1);
    checkOutput("one1", 4'b0100, 1'b1, 4'd12, 2'd2);
    applyStimulus(1'b1, 4'b0100, 1'b1);
    checkOutput("one2", 4'b0100, 1'b1, 4'd12, 2'd2);

    applyStimulus(1'b1, 4'b1000, 1'b1);
    checkOutput("sp0", 4'b1000, 1'b1, 4'd12, 2'd2);
    applyStimulus(1'b1, 4'b1010, 1'b1);
    checkOutput("sp1", 4'b0010, 1'b1, 4'd13, 2'd3);
    applyStimulus(1'b1, 4'b1010, 1'b1);
    checkOutput("sp2", 4'b1000, 1'b1, 4'd11, 2'd1);
    applyStimulus(1'b1, 4'b1010, 1'b1);
    checkOutput("sp3", 4'b0010, 1'b1, 4'd13, 2'd3);
    applyStimulus(1'b1, 4'b0000, 1'b1);
    checkOutput("sp4", 4'b0000, 1'b1, 4'd11, 2'd1);

    applyStimulus(1'b1, 4'b0100, 1'b1);
    checkOutput("mr0", 4'b0100, 1'b0, 4'd11, 2'd1);
    applyStimulus(1'b1, 4'b1111, 1'b0);
    checkOutput("mr1", 4'b0000, 1'b1, 4'd12, 2'd2);
    applyStimulus(1'b0, 4'b1111, 1'b0);
    checkOutput("mr2", 4'b0000, 1'b1, 4'd12, 2'd2);
    applyStimulus(1'b1, 4'b1111, 1'b1);
    checkOutput("mr3", 4'b0001, 1'b0, 4'd0, 2'd0);
    applyStimulus(1'b1, 4'b0000, 1'b1);
    checkOutput("mr4", 4'b0000, 1'b1, 4'd10, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
